// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, line levels and parity encoding.
// The RX side uses the same parity encoding.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity generator; even parity is the XOR of the data bits,
// odd parity is its complement.
module uart_parity_calc
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_par_typ,
    output logic                  o_par_bit
);

    logic w_xor;

    assign w_xor     = ^i_data;
    assign o_par_bit = (i_par_typ == PAR_ODD) ? ~w_xor : w_xor;

endmodule

// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start bit, DATA_WIDTH data bits LSB-first, optional
// parity bit, stop bit; one bit per clk. Back-to-back frames are accepted in STOP.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  tx_out,
    output logic                  busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    uart_state_e           r_state;
    uart_state_e           w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic                  r_par_en;
    logic                  w_par_en_nxt;
    logic                  r_par_bit;
    logic                  w_par_bit_nxt;
    logic                  r_tx;
    logic                  w_tx_nxt;
    logic                  r_busy;
    logic                  w_busy_nxt;
    logic                  w_par_calc;

    uart_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .i_data    (p_data),
        .i_par_typ (par_typ),
        .o_par_bit (w_par_calc)
    );

    // Next-state, next-output and capture logic; outputs are registered below.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_shift_nxt   = r_shift;
        w_par_en_nxt  = r_par_en;
        w_par_bit_nxt = r_par_bit;
        w_tx_nxt      = IDLE_LEVEL;
        w_busy_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (data_valid) begin
                    w_state_nxt   = START;
                    w_tx_nxt      = START_BIT;
                    w_busy_nxt    = 1'b1;
                    w_shift_nxt   = p_data;
                    w_par_en_nxt  = par_en;
                    w_par_bit_nxt = w_par_calc;
                    w_cnt_nxt     = '0;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            START: begin
                w_state_nxt = DATA;
                w_cnt_nxt   = '0;
                w_tx_nxt    = r_shift[0];
                w_busy_nxt  = 1'b1;
            end
            DATA: begin
                w_busy_nxt = 1'b1;
                if (r_cnt == CNT_LAST) begin
                    if (r_par_en) begin
                        w_state_nxt = PARITY;
                        w_tx_nxt    = r_par_bit;
                    end else begin
                        w_state_nxt = STOP;
                        w_tx_nxt    = STOP_BIT;
                    end
                end else begin
                    // Shift right so the next bit to send always sits at [0].
                    w_cnt_nxt   = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    w_shift_nxt = {1'b0, r_shift[DATA_WIDTH-1:1]};
                    w_tx_nxt    = r_shift[1];
                end
            end
            PARITY: begin
                w_state_nxt = STOP;
                w_tx_nxt    = STOP_BIT;
                w_busy_nxt  = 1'b1;
            end
            STOP: begin
                if (data_valid) begin
                    w_state_nxt   = START;
                    w_tx_nxt      = START_BIT;
                    w_busy_nxt    = 1'b1;
                    w_shift_nxt   = p_data;
                    w_par_en_nxt  = par_en;
                    w_par_bit_nxt = w_par_calc;
                    w_cnt_nxt     = '0;
                end else begin
                    w_state_nxt = IDLE;
                    w_tx_nxt    = IDLE_LEVEL;
                    w_busy_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_tx_nxt    = IDLE_LEVEL;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            r_tx      <= IDLE_LEVEL;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_par_en  <= w_par_en_nxt;
            r_par_bit <= w_par_bit_nxt;
            r_tx      <= w_tx_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    assign tx_out = r_tx;
    assign busy   = r_busy;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: an acceptance model queues expected frames,
// a line monitor decodes tx_out/busy and compares against them.
module tb_uart_tx_frame;

    logic       clk;
    logic       rst;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_en;
    logic       par_typ;
    logic       tx_out;
    logic       busy;

    uart_tx_frame #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .tx_out     (tx_out),
        .busy       (busy)
    );

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       pt;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   n_vec      = 0;
    int   n_err      = 0;
    int   cyc        = 0;
    int   busy_until = 0;
    int   n_acc      = 0;
    bit   mon_en     = 1'b1;

    bit s_a5  [11] = '{0,1,0,1,0,0,1,0,1,0,1};
    bit s_07o [11] = '{0,1,1,1,0,0,0,0,0,0,1};
    bit s_07n [11] = '{0,1,1,1,0,0,0,0,0,1,0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Acceptance model: a request is taken when the previous frame has reached its
    // stop-bit edge (or the line is idle); a frame occupies 10 or 11 bit times.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            busy_until = cyc;
        end else if (data_valid && cyc >= busy_until) begin
            n_acc++;
            if (mon_en) sb.push_back('{data: p_data, pe: par_en, pt: par_typ, cyc: cyc});
            busy_until = cyc + (par_en ? 11 : 10);
        end
    end

    // Line monitor: decodes each frame from tx_out and checks it against the queue.
    initial begin : monitor
        exp_t e;
        bit   fb [11];
        int   nb;
        forever begin
            @(negedge clk);
            if (mon_en && busy) begin
                if (sb.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("start_cycle", cyc, e.cyc);
                    fb[0] = 1'b0;
                    for (int i = 0; i < 8; i++) fb[1+i] = e.data[i];
                    nb = 10;
                    if (e.pe) begin
                        fb[9] = (^e.data) ^ e.pt;
                        nb = 11;
                    end
                    fb[nb-1] = 1'b1;
                    for (int i = 0; i < nb; i++) begin
                        if (i > 0) @(negedge clk);
                        chk("frame_bit", int'(tx_out), int'(fb[i]));
                        chk("frame_busy", int'(busy), 1);
                    end
                end
            end else if (mon_en) begin
                chk("idle_line", int'(tx_out), 1);
            end
        end
    end

    task automatic send_and_check(input logic [7:0] d, input logic pe, input logic pt,
                                  input bit seq [11], input int n);
        p_data = d; par_en = pe; par_typ = pt; data_valid = 1'b1;
        @(posedge clk); #1;
        data_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("seq_bit", int'(tx_out), int'(seq[i]));
            chk("seq_busy", int'(busy), 1);
        end
        @(negedge clk);
        chk("seq_busy_fall", int'(busy), 0);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("wait_idle_timeout", 0, 1);
    endtask

    initial begin : stim
        int n0;
        bit got;
        rst = 1'b1; data_valid = 1'b1; p_data = 8'hA5; par_en = 1'b1; par_typ = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_tx", int'(tx_out), 1);
            chk("rst_busy", int'(busy), 0);
        end
        rst = 1'b0;
        send_and_check(8'hA5, 1'b1, 1'b0, s_a5, 11);
        wait_idle();
        send_and_check(8'h07, 1'b1, 1'b1, s_07o, 11);
        wait_idle();
        send_and_check(8'h07, 1'b0, 1'b0, s_07n, 10);
        wait_idle();

        // Back-to-back: 8'h55 then 8'hFF with data_valid held high.
        p_data = 8'h55; par_en = 1'b0; par_typ = 1'b0; data_valid = 1'b1;
        @(posedge clk); #1;
        p_data = 8'hFF;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("b2b_busy", int'(busy), 1);
            if (i == 10) data_valid = 1'b0;
        end
        @(negedge clk);
        chk("b2b_busy_fall", int'(busy), 0);
        wait_idle();

        // Requests and input changes mid-frame must be ignored.
        p_data = 8'h3C; par_en = 1'b1; par_typ = 1'b1; data_valid = 1'b1;
        @(posedge clk); #1;
        data_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        data_valid = 1'b1; p_data = 8'h81; par_en = 1'b0; par_typ = 1'b0;
        @(posedge clk); #1;
        data_valid = 1'b0; p_data = 8'h00;
        wait_idle();

        // Reset during data bit 4 aborts the frame.
        mon_en = 1'b0;
        p_data = 8'hC3; par_en = 1'b1; par_typ = 1'b0; data_valid = 1'b1;
        @(posedge clk); #1;
        data_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_bit4", int'(tx_out), 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_tx", int'(tx_out), 1);
        chk("abort_busy", int'(busy), 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("post_abort_idle", int'(busy), 0);
        end
        mon_en = 1'b1;

        // Randomized traffic: 256 forced frames plus random extra requests.
        for (int f = 0; f < 256; f++) begin
            p_data = 8'($urandom); par_en = 1'($urandom); par_typ = 1'($urandom);
            data_valid = 1'b1;
            n0 = n_acc;
            got = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(posedge clk); #1;
                if (n_acc != n0) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) chk("accept_timeout", 0, 1);
            data_valid = 1'b0;
            for (int g = 0; g < int'($urandom_range(0, 12)); g++) begin
                p_data = 8'($urandom); par_en = 1'($urandom); par_typ = 1'($urandom);
                data_valid = ($urandom_range(0, 3) == 0);
                @(posedge clk); #1;
            end
            data_valid = 1'b0;
        end
        wait_idle();
        chk("queue_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
